regfile_port_sched: RTL

REGFILE_PORT_SCHED -- requirements
Module: regfile_port_sched

---
 rtl/regfile_port_sched_pkg.sv | 18 +
 rtl/regfile_port_sched_if.sv | 64 ++++++
 rtl/regfile_port_sched_rr_arb2.sv | 42 ++++
 rtl/regfile_port_sched.sv | 95 +++++++++
 4 files changed

// File: rtl/regfile_port_sched_pkg.sv
// Shared core constants and the round-robin pointer encoding for the register-file port scheduler.
package regfile_port_sched_pkg;

  localparam int unsigned CoreXlen = 32;
  localparam int unsigned CoreAw   = 5;

  // Which writeback requester wins the next contended cycle.
  typedef enum logic {
    RrWb0 = 1'b0,
    RrWb1 = 1'b1
  } rr_ptr_e;

  // After a grant, favour the requester that was not served.
  function automatic rr_ptr_e rr_next(input logic [1:0] gnt);
    return gnt[0] ? RrWb1 : RrWb0;
  endfunction

endpackage

// File: rtl/regfile_port_sched_if.sv
// Issue, writeback, operand-read and register-file port bundle for the scheduler.
interface regfile_port_sched_if
  import regfile_port_sched_pkg::*;
#(
  parameter int unsigned XLEN = CoreXlen,
  parameter int unsigned AW   = CoreAw
);

  logic            iss_valid;
  logic            iss_ready;
  logic [AW-1:0]   iss_rd;

  logic            wb0_valid;
  logic            wb0_ready;
  logic [AW-1:0]   wb0_addr;
  logic [XLEN-1:0] wb0_data;

  logic            wb1_valid;
  logic            wb1_ready;
  logic [AW-1:0]   wb1_addr;
  logic [XLEN-1:0] wb1_data;

  logic            rd_valid;
  logic            rd_ready;
  logic [AW-1:0]   rd_rs1;
  logic [AW-1:0]   rd_rs2;

  logic            rsp_valid;
  // Driven by the register file itself; the scheduler only qualifies it with rsp_valid.
  logic [XLEN-1:0] reg_rdata_1;
  logic [XLEN-1:0] reg_rdata_2;

  logic            reg_wen;
  logic [AW-1:0]   reg_waddr;
  logic [XLEN-1:0] reg_wdata;
  logic            reg_ren_1;
  logic [AW-1:0]   reg_raddr_1;
  logic            reg_ren_2;
  logic [AW-1:0]   reg_raddr_2;

  logic            flush;

  modport master (
    output iss_valid, iss_rd,
    output wb0_valid, wb0_addr, wb0_data,
    output wb1_valid, wb1_addr, wb1_data,
    output rd_valid, rd_rs1, rd_rs2, flush,
    input  iss_ready, wb0_ready, wb1_ready, rd_ready, rsp_valid,
    input  reg_rdata_1, reg_rdata_2,
    input  reg_wen, reg_waddr, reg_wdata,
    input  reg_ren_1, reg_raddr_1, reg_ren_2, reg_raddr_2
  );

  modport slave (
    input  iss_valid, iss_rd,
    input  wb0_valid, wb0_addr, wb0_data,
    input  wb1_valid, wb1_addr, wb1_data,
    input  rd_valid, rd_rs1, rd_rs2, flush,
    output iss_ready, wb0_ready, wb1_ready, rd_ready, rsp_valid,
    output reg_wen, reg_waddr, reg_wdata,
    output reg_ren_1, reg_raddr_1, reg_ren_2, reg_raddr_2
  );

endinterface

// File: rtl/regfile_port_sched_rr_arb2.sv
// Two-requester round-robin arbiter; pointer favours requester 0 out of reset.
module rr_arb2
  import regfile_port_sched_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  rr_ptr_e    r_ptr;
  rr_ptr_e    w_ptr_next;
  logic [1:0] w_gnt;

  // A lone requester always wins; contention is settled by the pointer.
  always_comb begin
    w_gnt = 2'b00;
    if (i_rstn) begin
      case (i_req)
        2'b01:   w_gnt = 2'b01;
        2'b10:   w_gnt = 2'b10;
        2'b11:   w_gnt = (r_ptr == RrWb0) ? 2'b01 : 2'b10;
        default: w_gnt = 2'b00;
      endcase
    end
  end

  // Pointer moves past whoever was just served.
  always_comb begin
    w_ptr_next = r_ptr;
    if (|w_gnt) w_ptr_next = rr_next(w_gnt);
  end

  // Pointer register with synchronous reset to requester 0.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) r_ptr <= RrWb0;
    else         r_ptr <= w_ptr_next;
  end

  assign o_gnt = w_gnt;

endmodule

// File: rtl/regfile_port_sched.sv
// Register-file port scheduler: busy-bit scoreboard, writeback arbitration and operand reads.
module regfile_port_sched
  import regfile_port_sched_pkg::*;
#(
  parameter int unsigned XLEN = CoreXlen,
  parameter int unsigned AW   = CoreAw
) (
  input logic                 hclk,
  input logic                 hrstn,
  regfile_port_sched_if.slave bus
);

  localparam int unsigned NumRegs = 1 << AW;

  logic [NumRegs-1:0] r_busy;
  logic [NumRegs-1:0] w_busy_next;
  logic               r_wen;
  logic [AW-1:0]      r_waddr;
  logic [XLEN-1:0]    r_wdata;
  logic               r_rsp_valid;

  logic [1:0]         w_gnt;
  logic               w_iss_ready;
  logic               w_rd_ready;
  logic               w_iss_fire;
  logic               w_rd_fire;
  logic               w_wb_fire;
  logic [AW-1:0]      w_wb_addr;
  logic [XLEN-1:0]    w_wb_data;

  rr_arb2 u_arb (
    .i_clk  (hclk),
    .i_rstn (hrstn),
    .i_req  ({bus.wb1_valid, bus.wb0_valid}),
    .o_gnt  (w_gnt)
  );

  // Readies look only at registered busy bits, so a write in flight unblocks a cycle later.
  always_comb begin
    w_iss_ready = hrstn & ~bus.flush & ~r_busy[bus.iss_rd];
    w_rd_ready  = hrstn & ~bus.flush & ~r_busy[bus.rd_rs1] & ~r_busy[bus.rd_rs2];
    w_iss_fire  = bus.iss_valid & w_iss_ready;
    w_rd_fire   = bus.rd_valid & w_rd_ready;
    w_wb_fire   = |w_gnt;
    w_wb_addr   = w_gnt[1] ? bus.wb1_addr : bus.wb0_addr;
    w_wb_data   = w_gnt[1] ? bus.wb1_data : bus.wb0_data;
  end

  // Scoreboard update: writes clear, issues set (set wins), flush wipes, x0 never busy.
  always_comb begin
    w_busy_next = r_busy;
    if (r_wen) w_busy_next[r_waddr] = 1'b0;
    if (w_iss_fire) w_busy_next[bus.iss_rd] = 1'b1;
    if (bus.flush) w_busy_next = '0;
    w_busy_next[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge hclk) begin
    if (!hrstn) r_busy <= '0;
    else        r_busy <= w_busy_next;
  end

  // Register the granted writeback and the read response strobe.
  always_ff @(posedge hclk) begin
    if (!hrstn) begin
      r_wen       <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_wen       <= w_wb_fire && (w_wb_addr != '0);
      if (w_wb_fire) begin
        r_waddr <= w_wb_addr;
        r_wdata <= w_wb_data;
      end
      r_rsp_valid <= w_rd_fire & ~bus.flush;
    end
  end

  assign bus.iss_ready   = w_iss_ready;
  assign bus.rd_ready    = w_rd_ready;
  assign bus.wb0_ready   = w_gnt[0];
  assign bus.wb1_ready   = w_gnt[1];
  // Gated by reset so a write or response caught by reset never reaches the register file.
  assign bus.reg_wen     = r_wen & hrstn;
  assign bus.rsp_valid   = r_rsp_valid & hrstn;
  assign bus.reg_waddr   = r_waddr;
  assign bus.reg_wdata   = r_wdata;
  assign bus.reg_ren_1   = w_rd_fire;
  assign bus.reg_ren_2   = w_rd_fire;
  assign bus.reg_raddr_1 = bus.rd_rs1;
  assign bus.reg_raddr_2 = bus.rd_rs2;

endmodule
